// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - SPI mode-0 master issuing spi_ram-style bursts
//
// One burst per accepted start: command byte (0x00 write / 0x01 read),
// 32-bit address MSB first, a dummy byte on reads, then len+1 data bytes,
// followed by c_cs_gap cycles with csn high before busy drops.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   start, rd, addr, len    burst request; rd/addr/len latched when start is accepted
//   wr_data, wr_valid       write byte source; wr_ready pulses when a byte is taken
//   rd_data, rd_valid       received read byte, rd_valid pulses once per byte
//   busy, done, underrun    status: burst active, end-of-burst pulse, sticky write underrun
//   csn, sclk, mosi, miso   SPI pins (mode 0, sclk idle low)
//
// Optional feature macro: SPI_RAM_MASTER_STALL_EN
//   defined   - a write byte boundary without wr_valid stalls with sclk low, csn low
//   undefined - 0x00 is sent for that byte and underrun is set

module spi_ram_master #(
  parameter int c_clk_div = 4,
  parameter int c_cs_gap  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        csn,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int DW = (c_clk_div > 1) ? $clog2(c_clk_div) : 1;
  localparam int GW = (c_cs_gap > 1) ? $clog2(c_cs_gap) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(c_clk_div - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(c_cs_gap - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          rd_q, rd_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sclk_q, sclk_d;
  logic [2:0]    bit_q, bit_d;
  logic [8:0]    byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_ready_q, wr_ready_d;
  logic          underrun_q, underrun_d;
  logic          stall_q, stall_d;
  logic          load_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      addr_q     <= 32'h0;
      len_q      <= 8'h0;
      div_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      bit_q      <= 3'd7;
      byte_q     <= 9'd0;
      shift_q    <= 8'h0;
      rx_q       <= 8'h0;
      rd_data_q  <= 8'h0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
      underrun_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ready_q <= wr_ready_d;
      underrun_q <= underrun_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    div_d      = div_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ready_d = 1'b0;
    underrun_d = underrun_q;
    stall_d    = stall_q;
    load_wr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_d       = rd;
          addr_d     = addr;
          len_d      = len;
          underrun_d = 1'b0;
          state_d    = S_CMD;
          shift_d    = {7'b0, rd};
          bit_d      = 3'd7;
          byte_d     = 9'd0;
          div_d      = '0;
          sclk_d     = 1'b0;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end

      default: begin
        if (stall_q) begin
          // Waiting for a write byte: the low phase restarts once it arrives.
          if (wr_valid) begin
            shift_d    = wr_data;
            wr_ready_d = 1'b1;
            stall_d    = 1'b0;
            div_d      = '0;
          end
        end else if (!sclk_q) begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], miso};
            if (state_q == S_DATA && rd_q && bit_q == 3'd0) begin
              rd_valid_d = 1'b1;
              rd_data_d  = {rx_q[6:0], miso};
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end else begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = 1'b0;
            if (bit_q != 3'd0) begin
              bit_d   = bit_q - 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
            end else begin
              // Byte boundary: pick the next byte for the following low phase.
              bit_d = 3'd7;
              case (state_q)
                S_CMD: begin
                  state_d = S_ADDR;
                  byte_d  = 9'd0;
                  shift_d = addr_q[31:24];
                end
                S_ADDR: begin
                  if (byte_q != 9'd3) begin
                    byte_d = byte_q + 9'd1;
                    case (byte_q[1:0])
                      2'd0:    shift_d = addr_q[23:16];
                      2'd1:    shift_d = addr_q[15:8];
                      default: shift_d = addr_q[7:0];
                    endcase
                  end else if (rd_q) begin
                    state_d = S_DUMMY;
                    byte_d  = 9'd0;
                    shift_d = 8'h00;
                  end else begin
                    state_d = S_DATA;
                    byte_d  = 9'd0;
                    load_wr = 1'b1;
                  end
                end
                S_DUMMY: begin
                  state_d = S_DATA;
                  byte_d  = 9'd0;
                  shift_d = 8'h00;
                end
                default: begin
                  if (byte_q == {1'b0, len_q}) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    shift_d = 8'h00;
                  end else begin
                    byte_d = byte_q + 9'd1;
                    if (rd_q) shift_d = 8'h00;
                    else      load_wr = 1'b1;
                  end
                end
              endcase
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
    endcase

    if (load_wr) begin
      if (wr_valid) begin
        shift_d    = wr_data;
        wr_ready_d = 1'b1;
      end else begin
        shift_d = 8'h00;
`ifdef SPI_RAM_MASTER_STALL_EN
        stall_d = 1'b1;
`else
        underrun_d = 1'b1;
`endif
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign csn      = (state_q == S_IDLE) || (state_q == S_GAP);
  assign done     = (state_q == S_GAP) && (gap_q == GAP_LAST);
  assign sclk     = sclk_q;
  assign mosi     = shift_q[7];
  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - self-checking bench for spi_ram_master

module tb_spi_ram_master;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [7:0]  len = 8'h0;
  logic [7:0]  wr_data;
  logic        wr_valid = 1'b1;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        csn;
  logic        sclk;
  logic        mosi;
  logic        miso;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] wr_src [0:511];
  logic [7:0] rd_src [0:511];
  logic [7:0] exp_data [$];

  // Observations of the SPI wire and local handshakes, cleared per burst.
  logic       mon_clr = 1'b0;
  int         rise_cnt, done_cnt, wr_ready_cnt, gap_cyc, csn_falls, low_run, max_low;
  logic [7:0] cur_byte;
  logic [8:0] wr_idx;
  logic [7:0] mosi_bytes [$];
  logic [7:0] rd_bytes [$];
  logic       csn_prev = 1'b1;
  logic       sclk_prev = 1'b0;
  logic [7:0] miso_byte;

  spi_ram_master #(.c_clk_div(CLK_DIV), .c_cs_gap(CS_GAP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rd(rd), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .underrun(underrun), .csn(csn), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  assign wr_data = wr_src[wr_idx];

  // Slave model: bytes 0..5 of a read burst are command/address/dummy, data follows.
  always_comb begin
    miso_byte = 8'h00;
    if (rise_cnt >= 48) miso_byte = rd_src[9'((rise_cnt / 8) - 6)];
    miso = miso_byte[3'(7 - (rise_cnt % 8))];
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      rise_cnt = 0; done_cnt = 0; wr_ready_cnt = 0; gap_cyc = 0; csn_falls = 0;
      low_run = 0; max_low = 0; cur_byte = 8'h00; wr_idx = 9'd0;
      mosi_bytes.delete();
      rd_bytes.delete();
    end else begin
      if (!csn && sclk && !sclk_prev) begin
        cur_byte = {cur_byte[6:0], mosi};
        rise_cnt = rise_cnt + 1;
        if (rise_cnt % 8 == 0) mosi_bytes.push_back(cur_byte);
      end
      if (!csn && !sclk) begin
        low_run = low_run + 1;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
      if (done) done_cnt = done_cnt + 1;
      if (wr_ready) begin
        wr_ready_cnt = wr_ready_cnt + 1;
        wr_idx = wr_idx + 9'd1;
      end
      if (rd_valid) rd_bytes.push_back(rd_data);
      if (csn && busy) gap_cyc = gap_cyc + 1;
      if (!csn && csn_prev) csn_falls = csn_falls + 1;
    end
    sclk_prev = sclk;
    csn_prev  = csn;
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic start_burst(input bit r, input logic [31:0] a, input logic [7:0] l);
    clear_mon();
    @(negedge clk);
    rd = r; addr = a; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_timeout got busy=%b want 0 after %0d cycles", name, busy, n);
    end
    @(negedge clk);
  endtask

  task automatic wait_rises(input string name, input int target);
    int n = 0;
    while (rise_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (rise_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s rise_timeout got %0d want %0d", name, rise_cnt, target);
    end
  endtask

  // Reference: the wire carries cmd, 4 address bytes MSB first, a dummy on
  // reads, then the data bytes; every bit is one sclk rise.
  task automatic check_burst(input string name, input bit r, input logic [31:0] a,
                             input logic [7:0] l, input int n_ready);
    logic [7:0] exp [$];
    int bad;
    exp.push_back(r ? 8'h01 : 8'h00);
    for (int i = 3; i >= 0; i--) exp.push_back(a[i*8 +: 8]);
    if (r) exp.push_back(8'h00);
    for (int i = 0; i <= int'(l); i++) exp.push_back(r ? 8'h00 : exp_data[i]);

    n_tests++;
    if (mosi_bytes.size() != exp.size()) begin
      n_fail++;
      $display("FAIL %s mosi_len got %0d want %0d", name, mosi_bytes.size(), exp.size());
    end else begin
      bad = -1;
      for (int i = 0; i < exp.size(); i++)
        if (bad < 0 && mosi_bytes[i] !== exp[i]) bad = i;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s mosi_byte[%0d] got %02h want %02h", name, bad, mosi_bytes[bad], exp[bad]);
      end
    end

    n_tests++;
    if (rise_cnt != ((r ? 6 : 5) + int'(l) + 1) * 8) begin
      n_fail++;
      $display("FAIL %s sclk_rises got %0d want %0d", name, rise_cnt, ((r ? 6 : 5) + int'(l) + 1) * 8);
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses got %0d want 1", name, done_cnt);
    end
    n_tests++;
    if (gap_cyc != CS_GAP) begin
      n_fail++;
      $display("FAIL %s cs_gap got %0d want %0d", name, gap_cyc, CS_GAP);
    end
    n_tests++;
    if (r) begin
      bad = (rd_bytes.size() != int'(l) + 1) ? 0 : -1;
      if (bad < 0)
        for (int i = 0; i <= int'(l); i++)
          if (bad < 0 && rd_bytes[i] !== exp_data[i]) bad = i;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s rd_bytes count %0d want %0d, first bad index %0d", name,
                 rd_bytes.size(), int'(l) + 1, bad);
      end
    end else if (wr_ready_cnt != n_ready) begin
      n_fail++;
      $display("FAIL %s wr_ready_pulses got %0d want %0d", name, wr_ready_cnt, n_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({csn, sclk, mosi, busy, done, wr_ready, rd_valid, underrun} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 10000000",
               {csn, sclk, mosi, busy, done, wr_ready, rd_valid, underrun});
    end
    n_tests++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rd_data got %02h want 00", rd_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    wr_src[0] = 8'hA5;
    exp_data = {8'hA5};
    start_burst(1'b0, 32'h0000_1234, 8'd0);
    wait_idle("write_basic");
    check_burst("write_basic", 1'b0, 32'h0000_1234, 8'd0, 1);
  endtask

  task automatic test_read_basic();
    rd_src[0] = 8'h3C;
    rd_src[1] = 8'hC3;
    exp_data = {8'h3C, 8'hC3};
    start_burst(1'b1, 32'h0000_0010, 8'd1);
    wait_idle("read_basic");
    check_burst("read_basic", 1'b1, 32'h0000_0010, 8'd1, 0);
  endtask

  task automatic test_random();
    bit r;
    logic [31:0] a;
    logic [7:0] l;
    repeat (6) begin
      r = 1'($urandom % 2);
      a = $urandom;
      l = 8'($urandom_range(0, 5));
      exp_data.delete();
      for (int i = 0; i <= int'(l); i++) begin
        wr_src[i] = 8'($urandom);
        rd_src[i] = 8'($urandom);
        exp_data.push_back(r ? rd_src[i] : wr_src[i]);
      end
      start_burst(r, a, l);
      wait_idle("random");
      check_burst("random", r, a, l, int'(l) + 1);
    end
  endtask

  task automatic test_long_write();
    logic [31:0] a;
    a = $urandom;
    exp_data.delete();
    for (int i = 0; i < 256; i++) begin
      wr_src[i] = 8'(i);
      exp_data.push_back(8'(i));
    end
    start_burst(1'b0, a, 8'd255);
    wait_idle("long_write");
    check_burst("long_write", 1'b0, a, 8'd255, 256);
    n_tests++;
    if (mosi_bytes.size() == 0 || mosi_bytes[mosi_bytes.size() - 1] !== 8'hFF) begin
      n_fail++;
      $display("FAIL long_write_last_byte got %02h want ff",
               (mosi_bytes.size() == 0) ? 8'h00 : mosi_bytes[mosi_bytes.size() - 1]);
    end
  endtask

  task automatic test_start_while_busy();
    exp_data.delete();
    for (int i = 0; i < 3; i++) begin
      wr_src[i] = 8'($urandom);
      exp_data.push_back(wr_src[i]);
    end
    start_burst(1'b0, 32'hCAFE_0042, 8'd2);
    wait_rises("start_busy", 20);
    rd = 1'b1; addr = 32'h1111_2222; len = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("start_busy");
    check_burst("start_busy", 1'b0, 32'hCAFE_0042, 8'd2, 3);
    repeat (20) @(negedge clk);
    n_tests++;
    if (csn_falls != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy_ignored got csn_falls=%0d busy=%b want 1 and 0", csn_falls, busy);
    end
  endtask

  task automatic test_reset_mid_addr();
    wr_src[0] = 8'h5A;
    start_burst(1'b0, 32'hDEAD_BEEF, 8'd3);
    wait_rises("reset_mid", 12);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({csn, sclk, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_mid_pins got csn,sclk,busy=%b want 100", {csn, sclk, busy});
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done got %0d want 0", done_cnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
    exp_data = {8'h5A};
    start_burst(1'b0, 32'h0BAD_F00D, 8'd0);
    wait_idle("after_reset");
    check_burst("after_reset", 1'b0, 32'h0BAD_F00D, 8'd0, 1);
  endtask

  task automatic test_wr_gap();
    for (int i = 0; i < 4; i++) wr_src[i] = 8'($urandom_range(1, 255));
    start_burst(1'b0, 32'h0000_0400, 8'd3);
    // 56 rises = cmd + addr + two data bytes; the next boundary is byte 2.
    wait_rises("wr_gap", 56);
    wr_valid = 1'b0;
    repeat (20) @(negedge clk);
    wr_valid = 1'b1;
    wait_idle("wr_gap");
`ifdef SPI_RAM_MASTER_STALL_EN
    exp_data = {wr_src[0], wr_src[1], wr_src[2], wr_src[3]};
    check_burst("wr_gap", 1'b0, 32'h0000_0400, 8'd3, 4);
    n_tests++;
    if (underrun !== 1'b0 || max_low < 20) begin
      n_fail++;
      $display("FAIL wr_gap_stall got underrun=%b max_low=%0d want 0 and >=20", underrun, max_low);
    end
`else
    exp_data = {wr_src[0], wr_src[1], 8'h00, wr_src[2]};
    check_burst("wr_gap", 1'b0, 32'h0000_0400, 8'd3, 3);
    n_tests++;
    if (underrun !== 1'b1 || max_low != CLK_DIV) begin
      n_fail++;
      $display("FAIL wr_gap_underrun got underrun=%b max_low=%0d want 1 and %0d",
               underrun, max_low, CLK_DIV);
    end
`endif
    wr_src[0] = 8'h77;
    exp_data = {8'h77};
    start_burst(1'b0, 32'h0000_0500, 8'd0);
    wait_idle("underrun_clear");
    check_burst("underrun_clear", 1'b0, 32'h0000_0500, 8'd0, 1);
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear got %b want 0", underrun);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      wr_src[i] = 8'h00;
      rd_src[i] = 8'h00;
    end
    clear_mon();
    test_reset();
    test_write_basic();
    test_read_basic();
    test_random();
    test_long_write();
    test_start_while_busy();
    test_reset_mid_addr();
    test_wr_gap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
